phase_hist_accum: RTL and testbench

PHASE_HIST_ACCUM -- requirements
Module: phase_hist_accum

---
 rtl/phase_hist_accum.sv | 118 +++++++++++
 tb/tb_phase_hist_accum.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/phase_hist_accum.sv
// Phase-binned photon histogram: live saturating counters, snapshot shadow bank, registered readout.
// Optional macro PHASE_HIST_COINC_EN adds per-bin detect[0]&detect[1] coincidence counters (needs NCH>=2).
module phase_hist_accum #(
    parameter int NCH   = 4,
    parameter int NBINS = 4,
    parameter int CW    = 32
) (
    input  logic                     clkin,
    input  logic                     resetn,
    input  logic                     locked,
    input  logic [$clog2(NBINS)-1:0] phase_bin,
    input  logic [NCH-1:0]           detect,
    input  logic                     resethist,
    input  logic                     snap,
    output logic                     snap_done,
    input  logic [7:0]               rd_addr,
    output logic [CW-1:0]            rd_data,
    output logic                     overflow
);

    localparam int BW    = $clog2(NBINS);
    localparam int NLIVE = NBINS * (NCH + 1);
`ifdef PHASE_HIST_COINC_EN
    localparam int NTOT  = NLIVE + NBINS;
`else
    localparam int NTOT  = NLIVE;
`endif
    localparam logic [CW-1:0] FULL = {CW{1'b1}};

    // Flat bank layout matches the read address map: cyc, then ph[c][b], then co[b].
    logic [1:0]    sync_q;
    logic          resethist_q;
    logic [CW-1:0] live_q   [NTOT];
    logic [CW-1:0] live_d   [NTOT];
    logic [CW-1:0] shadow_q [NTOT];
    logic [NTOT-1:0] inc;
    logic          ovf_q, ovf_d;
    logic          snap_done_q;
    logic [CW-1:0] rd_data_q, rd_data_d;
    logic          cnt_en;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v, input logic hit);
        if (hit && (v != FULL))
            return v + {{(CW-1){1'b0}}, 1'b1};
        return v;
    endfunction

    assign cnt_en = locked & sync_q[1];

    always_comb begin
        inc = '0;
        for (int b = 0; b < NBINS; b++) begin
            if (phase_bin == BW'(b)) begin
                inc[b] = 1'b1;
                for (int c = 0; c < NCH; c++)
                    inc[NBINS + c*NBINS + b] = detect[c];
`ifdef PHASE_HIST_COINC_EN
                inc[NLIVE + b] = detect[0] & detect[1];
`endif
            end
        end
    end

    always_comb begin
        ovf_d = ovf_q;
        for (int i = 0; i < NTOT; i++)
            live_d[i] = live_q[i];
        if (resethist_q) begin
            ovf_d = 1'b0;
            for (int i = 0; i < NTOT; i++)
                live_d[i] = '0;
        end else if (cnt_en) begin
            for (int i = 0; i < NTOT; i++) begin
                live_d[i] = sat_inc(live_q[i], inc[i]);
                if (inc[i] && (live_q[i] == FULL))
                    ovf_d = 1'b1;
            end
        end
    end

    // A read on a snapshot edge forwards the value being captured, so the new shadow value appears at once.
    always_comb begin
        rd_data_d = '0;
        for (int i = 0; i < NTOT; i++)
            if (int'(rd_addr) == i)
                rd_data_d = snap ? live_q[i] : shadow_q[i];
    end

    always_ff @(posedge clkin or negedge resetn) begin
        if (!resetn) begin
            sync_q      <= 2'b00;
            resethist_q <= 1'b0;
            ovf_q       <= 1'b0;
            snap_done_q <= 1'b0;
            rd_data_q   <= '0;
            for (int i = 0; i < NTOT; i++) begin
                live_q[i]   <= '0;
                shadow_q[i] <= '0;
            end
        end else begin
            sync_q      <= {sync_q[0], 1'b1};
            resethist_q <= resethist;
            ovf_q       <= ovf_d;
            snap_done_q <= snap;
            rd_data_q   <= rd_data_d;
            for (int i = 0; i < NTOT; i++) begin
                live_q[i] <= live_d[i];
                if (snap)
                    shadow_q[i] <= live_q[i];
            end
        end
    end

    assign snap_done = snap_done_q;
    assign rd_data   = rd_data_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_phase_hist_accum.sv
// Directed bench for phase_hist_accum: default instance plus a CW=8 instance for saturation.
module tb_phase_hist_accum;

    logic        clkin = 1'b0;
    logic        resetn;
    logic        locked, resethist, snap;
    logic [1:0]  phase_bin;
    logic [3:0]  detect;
    logic [7:0]  rd_addr;
    logic        snap_done, overflow;
    logic [31:0] rd_data;

    logic        locked8, resethist8, snap8;
    logic [1:0]  phase_bin8;
    logic [3:0]  detect8;
    logic [7:0]  rd_addr8;
    logic        snap_done8, overflow8;
    logic [7:0]  rd_data8;

    int checks = 0;
    int errors = 0;
    int coinc_exp;

    typedef struct {
        logic [7:0]  addr;
        logic [31:0] exp;
    } vec_t;
    vec_t tab[25];

    always #5 clkin = ~clkin;

    phase_hist_accum #(.NCH(4), .NBINS(4), .CW(32)) dut (
        .clkin(clkin), .resetn(resetn), .locked(locked), .phase_bin(phase_bin),
        .detect(detect), .resethist(resethist), .snap(snap), .snap_done(snap_done),
        .rd_addr(rd_addr), .rd_data(rd_data), .overflow(overflow)
    );

    phase_hist_accum #(.NCH(4), .NBINS(4), .CW(8)) dut8 (
        .clkin(clkin), .resetn(resetn), .locked(locked8), .phase_bin(phase_bin8),
        .detect(detect8), .resethist(resethist8), .snap(snap8), .snap_done(snap_done8),
        .rd_addr(rd_addr8), .rd_data(rd_data8), .overflow(overflow8)
    );

    task automatic tick();
        @(posedge clkin);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic snap_main();
        snap = 1'b1;
        tick();
        snap = 1'b0;
    endtask

    task automatic rd_main(input logic [7:0] a, input logic [31:0] exp, input string name);
        rd_addr = a;
        tick();
        chk(name, rd_data, exp);
    endtask

    initial begin
`ifdef PHASE_HIST_COINC_EN
        coinc_exp = 20;
`else
        coinc_exp = 0;
`endif
        for (int i = 0; i < 24; i++) begin
            tab[i].addr = 8'(i);
            tab[i].exp  = (i < 8) ? 32'd100 : 32'd0;
        end
        tab[24].addr = 8'd200;
        tab[24].exp  = 32'd0;

        resetn = 1'b0;
        locked = 0; resethist = 0; snap = 0; phase_bin = 0; detect = 0; rd_addr = 0;
        locked8 = 0; resethist8 = 0; snap8 = 0; phase_bin8 = 0; detect8 = 0; rd_addr8 = 0;
        #12;
        chk("reset_rd_data", rd_data, 0);
        chk("reset_overflow", {31'd0, overflow}, 0);
        chk("reset_snap_done", {31'd0, snap_done}, 0);
        resetn = 1'b1;
        tick(); tick(); tick();

        // Bins 0..3 cycled for 400 cycles with channel 0 firing every cycle
        locked = 1'b1;
        detect = 4'b0001;
        for (int i = 0; i < 400; i++) begin
            phase_bin = 2'(i % 4);
            tick();
        end
        locked = 1'b0;
        detect = 4'b0000;
        snap_main();
        chk("snap_done_pulse", {31'd0, snap_done}, 1);
        tick();
        chk("snap_done_clear", {31'd0, snap_done}, 0);
        chk("no_overflow", {31'd0, overflow}, 0);
        for (int k = 0; k < 25; k++) begin
            rd_addr = tab[k].addr;
            tick();
            chk($sformatf("table_addr%0d", tab[k].addr), rd_data, tab[k].exp);
        end

        // Unlocked with all channels firing: nothing may move
        detect = 4'b1111;
        for (int i = 0; i < 50; i++) begin
            phase_bin = 2'(i % 4);
            tick();
        end
        detect = 4'b0000;
        snap_main();
        rd_main(8'd0, 100, "unlocked_cyc0");
        rd_main(8'd4, 100, "unlocked_ph00");
        rd_main(8'd8, 0, "unlocked_ph10");
        rd_main(8'd15, 0, "unlocked_ph13");

        // Snapshot coinciding with a registered clear
        resethist = 1'b1; tick(); resethist = 1'b0; tick();
        locked = 1'b1; phase_bin = 2'd2;
        for (int i = 0; i < 10; i++) tick();
        locked = 1'b0;
        resethist = 1'b1; tick();
        resethist = 1'b0; snap = 1'b1; rd_addr = 8'd2; tick();
        snap = 1'b0;
        chk("snapclr_forward", rd_data, 10);
        tick();
        chk("snapclr_shadow", rd_data, 10);
        snap_main();
        tick();
        chk("snapclr_after", rd_data, 0);

        // Coincidence counting in bin 1
        resethist = 1'b1; tick(); resethist = 1'b0; tick();
        locked = 1'b1; phase_bin = 2'd1; detect = 4'b0011;
        for (int i = 0; i < 20; i++) tick();
        locked = 1'b0; detect = 4'b0000;
        snap_main();
        rd_main(8'd1, 20, "coinc_cyc1");
        rd_main(8'd5, 20, "coinc_ph01");
        rd_main(8'd9, 20, "coinc_ph11");
        rd_main(8'd13, 0, "coinc_ph21");
        rd_main(8'd21, 32'(coinc_exp), "coinc_co1");

        // Saturation on the 8-bit instance
        locked8 = 1'b1; phase_bin8 = 2'd0; detect8 = 4'b0001;
        for (int i = 0; i < 300; i++) tick();
        locked8 = 1'b0; detect8 = 4'b0000;
        chk("sat_overflow_set", {31'd0, overflow8}, 1);
        snap8 = 1'b1; tick(); snap8 = 1'b0;
        rd_addr8 = 8'd0; tick();
        chk("sat_cyc0", {24'd0, rd_data8}, 255);
        rd_addr8 = 8'd4; tick();
        chk("sat_ph00", {24'd0, rd_data8}, 255);
        resethist8 = 1'b1; tick(); resethist8 = 1'b0;
        chk("sat_overflow_hold", {31'd0, overflow8}, 1);
        tick();
        chk("sat_overflow_clr", {31'd0, overflow8}, 0);
        snap8 = 1'b1; tick(); snap8 = 1'b0;
        rd_addr8 = 8'd0; tick();
        chk("sat_after_clr", {24'd0, rd_data8}, 0);

        // Reset mid-run
        locked = 1'b1; detect = 4'b1111; locked8 = 1'b1;
        for (int i = 0; i < 260; i++) begin
            phase_bin = 2'(i % 4);
            tick();
        end
        locked8 = 1'b0;
        snap_main();
        rd_main(8'd0, 65, "prereset_cyc0");
        chk("prereset_overflow8", {31'd0, overflow8}, 1);
        phase_bin = 2'd0; snap = 1'b1;
        #2 resetn = 1'b0;
        #1;
        chk("midreset_rd_data", rd_data, 0);
        chk("midreset_overflow8", {31'd0, overflow8}, 0);
        chk("midreset_snap_done", {31'd0, snap_done}, 0);
        snap = 1'b0;
        #2 resetn = 1'b1;
        tick();
        locked = 1'b0; detect = 4'b0000;
        for (int i = 0; i < 24; i++)
            rd_main(8'(i), 0, $sformatf("postreset_addr%0d", i));
        rd_main(8'd200, 0, "postreset_addr200");
        chk("postreset_overflow", {31'd0, overflow}, 0);
        snap_main();
        rd_main(8'd0, 0, "first_edge_cyc0");
        rd_main(8'd4, 0, "first_edge_ph00");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
